// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared state encoding and default block sizes for accel_req_ctrl
package accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_UNLOAD  = 2'd3
  } accel_state_t;

  localparam int DEF_IN_WORDS  = 16;
  localparam int DEF_OUT_WORDS = 8;

  // Beat counters must hold the full block size, so size for max+1
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/accel_req_ctrl.sv
// rtl/accel_req_ctrl.sv - DMA request sequencer for a block accelerator (load, compute, unload)
module accel_req_ctrl
  import accel_pkg::*;
#(
  parameter int IN_WORDS  = DEF_IN_WORDS,
  parameter int OUT_WORDS = DEF_OUT_WORDS
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] num_blocks,
  input  logic        in_beat,
  input  logic        out_beat,
  input  logic        accel_done,
  output logic        ip_data_req,
  output logic        op_data_req,
  output logic        accel_start,
  output logic        busy,
  output logic        job_done,
  output logic        err
);

  localparam int CW = cnt_width(IN_WORDS, OUT_WORDS);
  localparam logic [CW-1:0] IN_LAST  = CW'(IN_WORDS - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_WORDS - 1);

  accel_state_t state, state_n;
  logic [CW-1:0] in_cnt, in_cnt_n;
  logic [CW-1:0] out_cnt, out_cnt_n;
  logic [15:0]   blk_rem, blk_rem_n;
  logic          accel_start_n, job_done_n, err_n;

  always_comb begin
    state_n       = state;
    in_cnt_n      = in_cnt;
    out_cnt_n     = out_cnt;
    blk_rem_n     = blk_rem;
    accel_start_n = 1'b0;
    job_done_n    = 1'b0;
    err_n         = 1'b0;
    if (abort) begin
      state_n   = ST_IDLE;
      in_cnt_n  = '0;
      out_cnt_n = '0;
      blk_rem_n = '0;
    end else begin
      // Misplaced events only raise err; they never touch counters or state
      err_n = (in_beat    && state != ST_LOAD)    ||
              (out_beat   && state != ST_UNLOAD)  ||
              (accel_done && state != ST_COMPUTE) ||
              (start && state == ST_IDLE && num_blocks == 16'd0);
      case (state)
        ST_IDLE: begin
          if (start && num_blocks != 16'd0) begin
            blk_rem_n = num_blocks;
            in_cnt_n  = '0;
            out_cnt_n = '0;
            state_n   = ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_beat) begin
            in_cnt_n = in_cnt + 1'b1;
            if (in_cnt == IN_LAST) begin
              state_n       = ST_COMPUTE;
              accel_start_n = 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (accel_done) begin
            out_cnt_n = '0;
            state_n   = ST_UNLOAD;
          end
        end
        ST_UNLOAD: begin
          if (out_beat) begin
            out_cnt_n = out_cnt + 1'b1;
            if (out_cnt == OUT_LAST) begin
              blk_rem_n = blk_rem - 1'b1;
              if (blk_rem == 16'd1) begin
                state_n    = ST_IDLE;
                job_done_n = 1'b1;
              end else begin
                in_cnt_n = '0;
                state_n  = ST_LOAD;
              end
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Level outputs are registered from the next state so they track the state exactly
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      in_cnt      <= '0;
      out_cnt     <= '0;
      blk_rem     <= '0;
      ip_data_req <= 1'b0;
      op_data_req <= 1'b0;
      accel_start <= 1'b0;
      busy        <= 1'b0;
      job_done    <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      in_cnt      <= in_cnt_n;
      out_cnt     <= out_cnt_n;
      blk_rem     <= blk_rem_n;
      ip_data_req <= (state_n == ST_LOAD);
      op_data_req <= (state_n == ST_UNLOAD);
      accel_start <= accel_start_n;
      busy        <= (state_n != ST_IDLE);
      job_done    <= job_done_n;
      err         <= err_n;
    end
  end

endmodule

// File: tb/tb_accel_req_ctrl.sv
// tb/tb_accel_req_ctrl.sv - self-checking bench for accel_req_ctrl against a job-level model
module tb_accel_req_ctrl;

  localparam int IN_W  = 16;
  localparam int OUT_W = 8;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0, abort = 1'b0, in_beat = 1'b0, out_beat = 1'b0, accel_done = 1'b0;
  logic [15:0] num_blocks = 16'd0;
  logic        ip_data_req, op_data_req, accel_start, busy, job_done, err;

  int n_checks = 0;
  int n_fail   = 0;

  accel_req_ctrl #(.IN_WORDS(IN_W), .OUT_WORDS(OUT_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .abort(abort), .num_blocks(num_blocks),
    .in_beat(in_beat), .out_beat(out_beat), .accel_done(accel_done),
    .ip_data_req(ip_data_req), .op_data_req(op_data_req), .accel_start(accel_start),
    .busy(busy), .job_done(job_done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level model: a phase name, words moved in the current phase, blocks still owed
  string m_phase = "idle";
  int    m_words = 0;
  int    m_blocks = 0;
  logic  e_ip = 0, e_op = 0, e_start = 0, e_busy = 0, e_done = 0, e_err = 0;

  initial forever begin
    @(posedge HCLK or posedge HRESET);
    e_start = 0; e_done = 0; e_err = 0;
    if (HRESET || abort) begin
      m_phase = "idle"; m_words = 0; m_blocks = 0;
    end else begin
      if (in_beat && m_phase != "load") e_err = 1;
      if (out_beat && m_phase != "unload") e_err = 1;
      if (accel_done && m_phase != "compute") e_err = 1;
      if (start && m_phase == "idle" && num_blocks == 0) e_err = 1;
      if (m_phase == "idle" && start && num_blocks != 0) begin
        m_blocks = num_blocks; m_words = 0; m_phase = "load";
      end else if (m_phase == "load" && in_beat) begin
        m_words++;
        if (m_words == IN_W) begin m_phase = "compute"; e_start = 1; end
      end else if (m_phase == "compute" && accel_done) begin
        m_phase = "unload"; m_words = 0;
      end else if (m_phase == "unload" && out_beat) begin
        m_words++;
        if (m_words == OUT_W) begin
          m_blocks--; m_words = 0;
          if (m_blocks == 0) begin m_phase = "idle"; e_done = 1; end
          else m_phase = "load";
        end
      end
    end
    e_ip = (m_phase == "load");
    e_op = (m_phase == "unload");
    e_busy = (m_phase != "idle");
  end

  int   n_astart = 0, n_done = 0, n_ip = 0, n_op = 0, n_load_entry = 0;
  logic prev_ip = 0;

  initial forever begin
    @(negedge HCLK);
    check_bit("ip_data_req", ip_data_req, e_ip);
    check_bit("op_data_req", op_data_req, e_op);
    check_bit("accel_start", accel_start, e_start);
    check_bit("busy", busy, e_busy);
    check_bit("job_done", job_done, e_done);
    check_bit("err", err, e_err);
    if (accel_start) n_astart++;
    if (job_done) n_done++;
    if (ip_data_req) n_ip++;
    if (op_data_req) n_op++;
    if (ip_data_req && !prev_ip) n_load_entry++;
    prev_ip = ip_data_req;
  end

  task automatic tick();
    @(negedge HCLK);
    #1;
    start = 0; abort = 0; in_beat = 0; out_beat = 0; accel_done = 0;
  endtask

  task automatic clear_stats();
    n_astart = 0; n_done = 0; n_ip = 0; n_op = 0; n_load_entry = 0;
  endtask

  task automatic drain(input bit rnd);
    for (int c = 0; c < 4000 && busy; c++) begin
      if (rnd) begin
        in_beat    = ip_data_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0);
        out_beat   = op_data_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0);
        accel_done = (!ip_data_req && !op_data_req) ? ($urandom_range(0, 2) == 0)
                                                    : ($urandom_range(0, 24) == 0);
        start      = ($urandom_range(0, 29) == 0);
        num_blocks = 16'($urandom_range(0, 65535));
        abort      = ($urandom_range(0, 299) == 0);
      end else begin
        in_beat    = ip_data_req;
        out_beat   = op_data_req;
        accel_done = !ip_data_req && !op_data_req;
      end
      tick();
    end
    check_bit("job_timeout_busy", busy, 1'b0);
  endtask

  task automatic run_job(input int nb, input bit rnd);
    start = 1; num_blocks = 16'(nb);
    tick();
    drain(rnd);
  endtask

  task automatic beats_until_drop(output int cnt);
    cnt = 0;
    for (int c = 0; c < 100 && ip_data_req; c++) begin in_beat = 1; cnt++; tick(); end
  endtask

  task automatic obeats_until_drop(output int cnt);
    cnt = 0;
    for (int c = 0; c < 100 && op_data_req; c++) begin out_beat = 1; cnt++; tick(); end
  endtask

  int cnt;

  initial begin
    repeat (3) tick();
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_ip", ip_data_req, 1'b0);
    HRESET = 0;
    tick();

    // Single block, back-to-back beats
    clear_stats();
    run_job(1, 0);
    check_int("one_blk_accel_start", n_astart, 1);
    check_int("one_blk_job_done", n_done, 1);
    check_int("one_blk_ip_cycles", n_ip, IN_W);
    check_int("one_blk_op_cycles", n_op, OUT_W);
    check_bit("one_blk_busy_after", busy, 1'b0);

    // Three blocks
    clear_stats();
    run_job(3, 0);
    check_int("three_blk_accel_start", n_astart, 3);
    check_int("three_blk_load_entries", n_load_entry, 3);
    check_int("three_blk_op_cycles", n_op, 3 * OUT_W);
    check_int("three_blk_job_done", n_done, 1);

    // Abort coinciding with the eighth input beat
    clear_stats();
    start = 1; num_blocks = 16'd1; tick();
    repeat (7) begin in_beat = 1; tick(); end
    in_beat = 1; abort = 1; tick();
    check_bit("abort_ip", ip_data_req, 1'b0);
    check_bit("abort_busy", busy, 1'b0);
    repeat (3) tick();
    check_int("abort_no_start", n_astart, 0);
    check_int("abort_no_done", n_done, 0);
    start = 1; num_blocks = 16'd1; tick();
    beats_until_drop(cnt);
    check_int("after_abort_beats", cnt, IN_W);
    drain(0);

    // Zero-block start, then start while computing
    start = 1; num_blocks = 16'd0; tick();
    check_bit("zero_blk_err", err, 1'b1);
    check_bit("zero_blk_busy", busy, 1'b0);
    tick();
    check_bit("zero_blk_err_one_cycle", err, 1'b0);
    clear_stats();
    start = 1; num_blocks = 16'd2; tick();
    beats_until_drop(cnt);
    start = 1; num_blocks = 16'd5; tick();
    check_bit("start_in_compute_err", err, 1'b0);
    check_bit("start_in_compute_busy", busy, 1'b1);
    drain(0);
    check_int("start_in_compute_blocks", n_astart, 2);

    // Misplaced events leave counters alone
    clear_stats();
    start = 1; num_blocks = 16'd1; tick();
    repeat (4) begin in_beat = 1; tick(); end
    out_beat = 1; tick();
    check_bit("out_beat_in_load_err", err, 1'b1);
    beats_until_drop(cnt);
    check_int("load_remaining_beats", cnt, IN_W - 4);
    accel_done = 1; tick();
    repeat (3) begin out_beat = 1; tick(); end
    accel_done = 1; tick();
    check_bit("done_in_unload_err", err, 1'b1);
    obeats_until_drop(cnt);
    check_int("unload_remaining_beats", cnt, OUT_W - 3);
    check_int("misplaced_job_done", n_done, 1);

    // Asynchronous reset in the middle of unloading
    start = 1; num_blocks = 16'd1; tick();
    beats_until_drop(cnt);
    accel_done = 1; tick();
    repeat (5) begin out_beat = 1; tick(); end
    check_bit("pre_reset_op", op_data_req, 1'b1);
    HRESET = 1;
    #1;
    check_bit("async_reset_op", op_data_req, 1'b0);
    check_bit("async_reset_busy", busy, 1'b0);
    tick(); tick();
    HRESET = 0; start = 1; num_blocks = 16'd1; tick();
    check_bit("first_start_after_reset", busy, 1'b1);
    drain(0);

    // Idle-state errant traffic
    for (int i = 0; i < 40; i++) begin
      in_beat = $urandom_range(0, 3) == 0;
      out_beat = $urandom_range(0, 3) == 0;
      accel_done = $urandom_range(0, 3) == 0;
      start = $urandom_range(0, 4) == 0;
      num_blocks = 16'd0;
      abort = $urandom_range(0, 7) == 0;
      tick();
    end

    // Randomized jobs with stray events and rare aborts
    for (int j = 0; j < 30; j++) begin
      run_job($urandom_range(1, 4), 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
